// File: rtl/spi_mem_seq.sv
// Turns single-byte bus memory requests into SPI SRAM transactions
// (command, address high, address low, data) over a byte-shift engine handshake.
module spi_mem_seq #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req_address,
  input  logic [7:0]  req_wdata,
  input  logic        req_read,
  input  logic        req_write,
  output logic        req_ready,
  output logic [7:0]  req_rdata,
  output logic        req_done,
  output logic        spi_cs_n,
  output logic [7:0]  spi_data_tx,
  input  logic [7:0]  spi_data_rx,
  output logic        spi_start,
  input  logic        spi_done
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_HI,
    ADDR_LO,
    DATA,
    FINISH
  } state_t;

  state_t      state_q, state_d;
  logic        wait_q, wait_d;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        op_read_q;
  logic [7:0]  rdata_q;
  logic [7:0]  byte_sel;
  state_t      next_byte;
  logic        accept;
  logic        capture_rx;

  assign accept     = (state_q == IDLE) && (req_read || req_write);
  assign capture_rx = (state_q == DATA) && wait_q && spi_done && op_read_q;
  assign req_rdata  = rdata_q;

  always_comb begin
    byte_sel  = '0;
    next_byte = IDLE;
    unique case (state_q)
      CMD: begin
        byte_sel  = op_read_q ? CMD_READ : CMD_WRITE;
        next_byte = ADDR_HI;
      end
      ADDR_HI: begin
        byte_sel  = addr_q[15:8];
        next_byte = ADDR_LO;
      end
      ADDR_LO: begin
        byte_sel  = addr_q[7:0];
        next_byte = DATA;
      end
      DATA: begin
        byte_sel  = op_read_q ? 8'h00 : wdata_q;
        next_byte = FINISH;
      end
      default: begin
        byte_sel  = '0;
        next_byte = IDLE;
      end
    endcase
  end

  // wait_q splits each byte state into its issue cycle (0) and wait phase (1)
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    req_ready   = 1'b0;
    req_done    = 1'b0;
    spi_cs_n    = 1'b1;
    spi_start   = 1'b0;
    spi_data_tx = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_read || req_write) begin
          state_d = CMD;
          wait_d  = 1'b0;
        end
      end
      CMD, ADDR_HI, ADDR_LO, DATA: begin
        spi_cs_n    = 1'b0;
        spi_start   = !wait_q;
        spi_data_tx = byte_sel;
        if (!wait_q) begin
          wait_d = 1'b1;
        end else if (spi_done) begin
          wait_d  = 1'b0;
          state_d = next_byte;
        end
      end
      FINISH: begin
        req_done = 1'b1;
        state_d  = IDLE;
        wait_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        wait_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wait_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_read_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (accept) begin
        addr_q    <= req_address;
        wdata_q   <= req_wdata;
        op_read_q <= req_read;
      end
      if (capture_rx) begin
        rdata_q <= spi_data_rx;
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_seq.sv
// Directed bench for spi_mem_seq with a behavioural byte engine of programmable per-byte latency.
module tb_spi_mem_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] req_address;
  logic [7:0]  req_wdata;
  logic        req_read;
  logic        req_write;
  logic        req_ready;
  logic [7:0]  req_rdata;
  logic        req_done;
  logic        spi_cs_n;
  logic [7:0]  spi_data_tx;
  logic [7:0]  spi_data_rx;
  logic        spi_start;
  logic        spi_done;
  logic        eng_done;
  logic        inject_done;

  int total = 0;
  int bad   = 0;

  int       eng_d[4];
  logic [7:0] eng_rx;
  int       eng_cnt;
  int       eng_idx;

  logic [31:0] got_tx;
  logic [31:0] got_st;
  int          got_n;
  int          got_done;
  int          got_cs;
  int          got_stable_bad;
  logic        got_ready1;
  logic [7:0]  got_rdata;

  assign spi_done = eng_done | inject_done;

  spi_mem_seq #(.CMD_READ(8'h03), .CMD_WRITE(8'h02)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_address(req_address), .req_wdata(req_wdata),
    .req_read(req_read), .req_write(req_write),
    .req_ready(req_ready), .req_rdata(req_rdata), .req_done(req_done),
    .spi_cs_n(spi_cs_n), .spi_data_tx(spi_data_tx), .spi_data_rx(spi_data_rx),
    .spi_start(spi_start), .spi_done(spi_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine: done pulse D cycles after the start pulse; only the 4th byte returns eng_rx
  always @(negedge clk) begin
    eng_done = 1'b0;
    if (spi_cs_n) eng_idx = 0;
    if (spi_start) begin
      eng_cnt = (eng_idx < 4) ? eng_d[eng_idx] : 1;
      eng_idx = eng_idx + 1;
    end else if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) begin
        eng_done    = 1'b1;
        spi_data_rx = (eng_idx == 4) ? eng_rx : 8'hEE;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_d(input int d0, input int d1, input int d2, input int d3);
    eng_d[0] = d0; eng_d[1] = d1; eng_d[2] = d2; eng_d[3] = d3;
  endtask

  // Presents one request in the current cycle and follows it to req_done (bounded).
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] wd);
    logic [7:0] last_tx;
    got_tx = '0; got_st = '0; got_n = 0; got_done = -1; got_cs = 0;
    got_stable_bad = 0; got_ready1 = 1'b1; got_rdata = '0; last_tx = '0;
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    req_read = rd; req_write = wr; req_address = a; req_wdata = wd;
    for (int c = 1; c <= 300; c++) begin
      tick();
      req_read = 1'b0; req_write = 1'b0;
      if (c == 1) got_ready1 = req_ready;
      if (!spi_cs_n) got_cs++;
      if (spi_start) begin
        if (got_n < 4) begin
          got_tx = {got_tx[23:0], spi_data_tx};
          got_st = {got_st[23:0], 8'(c)};
        end
        got_n++;
        last_tx = spi_data_tx;
      end else if (!spi_cs_n && spi_data_tx !== last_tx) begin
        got_stable_bad++;
      end
      if (req_done) begin
        got_done  = c;
        got_rdata = req_rdata;
        break;
      end
    end
  endtask

  // Expected start/done/cs timing derived from the engine delays.
  task automatic check_txn(input string p, input logic [31:0] exp_tx, input logic [7:0] exp_rdata);
    int s;
    logic [31:0] exp_st;
    s = 1; exp_st = '0;
    for (int k = 0; k < 4; k++) begin
      exp_st = {exp_st[23:0], 8'(s)};
      s = s + eng_d[k] + 1;
    end
    chk({p, "_done_cycle"}, 32'(got_done), 32'(s));
    chk({p, "_tx_bytes"}, got_tx, exp_tx);
    chk({p, "_start_cycles"}, got_st, exp_st);
    chk({p, "_nstarts"}, 32'(got_n), 32'd4);
    chk({p, "_cs_low_cycles"}, 32'(got_cs), 32'(s - 1));
    chk({p, "_ready_low_T1"}, 32'(got_ready1), 32'd0);
    chk({p, "_rdata"}, 32'(got_rdata), 32'(exp_rdata));
    chk({p, "_tx_stable"}, 32'(got_stable_bad), 32'd0);
    tick();
    chk({p, "_done_one_pulse"}, 32'(req_done), 32'd0);
    chk({p, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          d;
    logic [7:0]  rx;
    logic [31:0] exp_tx;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int nst, nd, d1, d2, s5, hi, idle_starts;
    logic [31:0] tx2;

    vecs[0] = '{1'b1, 1'b0, 16'h1234, 8'h00, 3, 8'hA5, 32'h03123400, 8'hA5};
    vecs[1] = '{1'b0, 1'b1, 16'hBEEF, 8'h5A, 2, 8'h77, 32'h02BEEF5A, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 16'h0001, 8'h99, 1, 8'h3C, 32'h03000100, 8'h3C};
    vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 8'h11, 8, 8'h00, 32'h03FFFF00, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 8'hFF, 1, 8'h77, 32'h020000FF, 8'h00};

    rst_n = 1'b0; req_address = '0; req_wdata = '0; req_read = 1'b0; req_write = 1'b0;
    spi_data_rx = '0; eng_done = 1'b0; inject_done = 1'b0; eng_cnt = 0; eng_idx = 0;
    eng_rx = '0; set_d(1, 1, 1, 1);

    tick(); tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rdata", 32'(req_rdata), 32'h00);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_tx", 32'(spi_data_tx), 32'h00);
    chk("rst_start", 32'(spi_start), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      set_d(vecs[i].d, vecs[i].d, vecs[i].d, vecs[i].d);
      eng_rx = vecs[i].rx;
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check_txn($sformatf("vec%0d", i), vecs[i].exp_tx, vecs[i].exp_rdata);
      idle_starts = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (spi_start || !spi_cs_n) idle_starts++;
      end
      chk($sformatf("vec%0d_idle_after", i), 32'(idle_starts), 32'd0);
    end

    // Long ADDR_HI wait, then a spurious done while idle
    set_d(2, 20, 2, 2);
    eng_rx = 8'hC3;
    run_txn(1'b1, 1'b0, 16'h1234, 8'h00);
    check_txn("stall", 32'h03123400, 8'hC3);
    inject_done = 1'b1;
    tick();
    inject_done = 1'b0;
    chk("spurious_ready", 32'(req_ready), 32'd1);
    chk("spurious_start", 32'(spi_start), 32'd0);
    chk("spurious_cs_n", 32'(spi_cs_n), 32'd1);
    idle_starts = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (spi_start || req_done || !req_ready) idle_starts++;
    end
    chk("spurious_quiet", 32'(idle_starts), 32'd0);

    // Back-to-back reads with req_read held
    set_d(2, 2, 2, 2);
    eng_rx = 8'h44;
    req_read = 1'b1; req_address = 16'h0102;
    nst = 0; nd = 0; d1 = -1; d2 = -1; s5 = -1; hi = 0; tx2 = '0;
    for (int c = 1; c <= 120; c++) begin
      tick();
      if (spi_start) begin
        nst++;
        if (nst >= 5) tx2 = {tx2[23:0], spi_data_tx};
        if (nst == 5) begin s5 = c; req_read = 1'b0; end
      end
      if (req_done) begin
        nd++;
        if (nd == 1) d1 = c; else d2 = c;
      end
      if (spi_cs_n && d1 >= 0 && s5 < 0) hi++;
      if (nd == 2) break;
    end
    chk("b2b_done1", 32'(d1), 32'd13);
    chk("b2b_cmd2_start", 32'(s5), 32'd15);
    chk("b2b_cs_high_gap", 32'(hi), 32'd2);
    chk("b2b_done2", 32'(d2), 32'd27);
    chk("b2b_tx2", tx2, 32'h03010200);
    chk("b2b_nstarts", 32'(nst), 32'd8);
    chk("b2b_rdata", 32'(req_rdata), 32'h44);
    tick();

    // Reset in the ADDR_LO wait phase (ADDR_LO start at cycle 13 with D=5)
    set_d(5, 5, 5, 5);
    eng_rx = 8'h11;
    req_read = 1'b1; req_address = 16'h1234;
    for (int c = 1; c <= 15; c++) begin
      tick();
      req_read = 1'b0;
    end
    chk("prerst_tx", 32'(spi_data_tx), 32'h34);
    chk("prerst_cs_n", 32'(spi_cs_n), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_rdata", 32'(req_rdata), 32'h00);
    chk("midrst_start", 32'(spi_start), 32'd0);
    chk("midrst_done", 32'(req_done), 32'd0);
    idle_starts = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (spi_start || req_done || !req_ready) idle_starts++;
    end
    chk("midrst_quiet", 32'(idle_starts), 32'd0);
    set_d(1, 1, 1, 1);
    eng_rx = 8'h5E;
    run_txn(1'b1, 1'b0, 16'h00AB, 8'h00);
    check_txn("postrst", 32'h0300AB00, 8'h5E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_mem_seq.md
# spi_mem_seq

Sequencer that turns single-byte bus memory requests into complete SPI SRAM transactions: command byte, 16-bit address (MSB first), then one data byte. Sits between the memory controller (requester side) and the SPI byte-shift engine (transfer side), owns chip select, and issues one byte transfer at a time via a start/done handshake. It is the only block that drives the external SRAM chip select.

## Interface

- `CMD_READ`, 8'h03, SPI read opcode
- `CMD_WRITE`, 8'h02, SPI write opcode
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_address`  in  16  byte address, sampled on acceptance
- `req_wdata`  in  8  write data, sampled on acceptance
- `req_read`  in  1  read request, level
- `req_write`  in  1  write request, level
- `req_ready`  out  1  high only in IDLE; a request is accepted when ready and read or write are high
- `req_rdata`  out  8  read result, valid from the `req_done` cycle until the next read completes
- `req_done`  out  1  one-cycle pulse at transaction end (read and write)
- `spi_cs_n`  out  1  SRAM chip select, active low
- `spi_data_tx`  out  8  byte to shift out, stable from start until done
- `spi_data_rx`  in  8  byte shifted in, valid in the `spi_done` cycle
- `spi_start`  out  1  one-cycle pulse launching a byte transfer
- `spi_done`  in  1  one-cycle pulse from the engine when a byte completes

## Operation

- States: IDLE, CMD, ADDR_HI, ADDR_LO, DATA, FINISH.
- Reset value of every output: `req_ready`=1, `req_rdata`=8'h00, `req_done`=0, `spi_cs_n`=1, `spi_data_tx`=8'h00, `spi_start`=0. State is IDLE. Latched address, data and op are cleared.
- IDLE: on acceptance, latch address, wdata and op, then go to CMD. If `req_read` and `req_write` are both high, read wins. The write is not latched and is accepted later only if still held.
- Each byte state has two phases.
  - Issue: one cycle with `spi_start`=1 and `spi_data_tx` set to the state's byte.
  - Wait: `spi_start`=0 and `spi_data_tx` held until `spi_done`.
- Bytes per state:
  - CMD: CMD_READ or CMD_WRITE.
  - ADDR_HI: address[15:8].
  - ADDR_LO: address[7:0].
  - DATA: 8'h00 for a read, latched wdata for a write.
- `spi_done` advances the state to the next byte's issue phase. `spi_done` is ignored in the issue cycle, in IDLE and in FINISH.
- DATA read: `req_rdata` <= `spi_data_rx` in the `spi_done` cycle. A write leaves `req_rdata` unchanged.
- FINISH: `spi_cs_n`=1, `req_done`=1, `spi_data_tx`=8'h00, then go to IDLE.
- `spi_cs_n`:
  - Low from the CMD issue cycle through the DATA `spi_done` cycle inclusive.
  - High in FINISH and IDLE.
  - Between back-to-back transactions it is therefore high for at least 2 cycles (FINISH + the accepting IDLE cycle).
- No timeout. A missing `spi_done` stalls the block indefinitely; only reset recovers it.

## Timing

- Acceptance at cycle T. The engine returns `spi_done` D≥1 cycles after `spi_start`.
- Byte k (k=0..3) start pulse at T+1+k(D+1); its done at T+1+k(D+1)+D.
- `req_done` at T+5+4D; `req_ready` high again at T+6+4D. Example: D=8 gives `req_done` at T+37.
- `req_ready` falls in cycle T+1, the cycle after acceptance.
- Reset mid-transaction: at the first edge with `rst_n`=0, all outputs take reset values (`spi_cs_n`=1, `spi_start`=0, no `req_done`). Any in-flight `spi_done` after reset is ignored.

## Test plan

- Read 0x1234, engine D=3 echoing 8'hA5 on the data byte.
  - TX bytes in order: 03, 12, 34, 00.
  - `req_rdata`=A5 and `req_done` pulse at T+17.
  - `spi_cs_n` low exactly across the 4 bytes.
- Write 0xBEEF with data 8'h5A.
  - TX bytes: 02, BE, EF, 5A.
  - `req_done` pulses once; `req_rdata` keeps its previous value.
- `req_read` and `req_write` both held high for one cycle with address 0x0001.
  - A read transaction runs (CMD byte 03).
  - No write occurs once both requests are dropped.
- Back-to-back reads with requests held high: `spi_cs_n` high for exactly 2 cycles between transactions; second read's CMD start at the first's `req_done` + 2.
- Engine delays `spi_done` 20 cycles on ADDR_HI, and a spurious `spi_done` is injected in IDLE.
  - `spi_data_tx`=12 stable throughout the wait.
  - The spurious done causes no state change.
- Assert `rst_n`=0 for one cycle during ADDR_LO wait.
  - Next cycle: `spi_cs_n`=1, `req_ready`=1, `req_rdata`=00.
  - A subsequent read completes normally.
